// File: rtl/spi_mcu_framer.sv
// spi_mcu_framer: MCU serial link framer.
// Deframes interest records from rx_line; frames buffered data packets onto tx_line.
module spi_mcu_framer #(
  parameter int PREFIX_W      = 64,
  parameter int PAYLOAD_BYTES = 32,
  parameter int IFG_BITS      = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rx_line,
  output logic                tx_line,
  output logic                rx_valid,
  input  logic                rx_ready,
  output logic [5:0]          rx_length,
  output logic [PREFIX_W-1:0] rx_prefix,
  output logic                rx_err,
  output logic [1:0]          rx_err_code,
  output logic                rx_drop,
  input  logic [7:0]          tx_data,
  input  logic                tx_data_valid,
  output logic                tx_data_ready,
  output logic                tx_busy
);

  localparam int RCW = $clog2(PREFIX_W);
  localparam int BW  = 8 * PAYLOAD_BYTES;
  localparam int TCW = $clog2(BW);
  localparam int IFW = (IFG_BITS > 1) ? $clog2(IFG_BITS) : 1;

  typedef enum logic [2:0] {
    R_ARM, R_IDLE, R_HDR, R_PFX, R_END, R_CHECK
  } rx_st_t;

  typedef enum logic [2:0] {
    T_LOAD, T_START, T_HDR, T_BODY, T_END, T_IFG
  } tx_st_t;

  rx_st_t              r_rx_st;
  logic [RCW-1:0]      r_rx_cnt;
  logic [6:0]          r_hdr;
  logic [PREFIX_W-1:0] r_sh;
  logic                r_endb;
  logic                r_rx_valid;
  logic [5:0]          r_rx_len;
  logic [PREFIX_W-1:0] r_rx_pfx;
  logic                r_rx_err;
  logic [1:0]          r_rx_code;
  logic                r_rx_drop;
  logic                w_len_bad;

  tx_st_t              r_tx_st;
  logic [TCW-1:0]      r_tcnt;
  logic [IFW-1:0]      r_ifg;
  logic [TCW-1:0]      r_woff;
  logic [BW-1:0]       r_buf;
  logic                r_line;
  logic                r_trdy;
  logic                r_busy;
  logic [TCW-1:0]      w_bidx;
  logic                w_acc;

  assign w_len_bad = (r_hdr[5:0] == 6'd0) ||
                     ({1'b0, r_hdr[5:0]} > 7'(PREFIX_W / 8));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_st    <= R_ARM;
      r_rx_cnt   <= '0;
      r_hdr      <= '0;
      r_sh       <= '0;
      r_endb     <= 1'b0;
      r_rx_valid <= 1'b0;
      r_rx_len   <= '0;
      r_rx_pfx   <= '0;
      r_rx_err   <= 1'b0;
      r_rx_code  <= 2'b00;
      r_rx_drop  <= 1'b0;
    end else begin
      r_rx_err  <= 1'b0;
      r_rx_drop <= 1'b0;
      if (r_rx_valid && rx_ready)
        r_rx_valid <= 1'b0;
      unique case (r_rx_st)
        R_ARM: if (rx_line) r_rx_st <= R_IDLE;
        R_IDLE: begin
          if (!rx_line) begin
            r_rx_cnt <= '0;
            r_rx_st  <= R_HDR;
          end
        end
        R_HDR: begin
          r_hdr <= {r_hdr[5:0], rx_line};
          if (r_rx_cnt == RCW'(7)) begin
            r_rx_cnt <= '0;
            r_rx_st  <= R_PFX;
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        R_PFX: begin
          r_sh <= {r_sh[PREFIX_W-2:0], rx_line};
          if (r_rx_cnt == RCW'(PREFIX_W - 1))
            r_rx_st <= R_END;
          else
            r_rx_cnt <= r_rx_cnt + 1'b1;
        end
        R_END: begin
          r_endb  <= rx_line;
          r_rx_st <= R_CHECK;
        end
        R_CHECK: begin
          r_rx_st <= R_ARM;
          if (r_endb) begin
            r_rx_err  <= 1'b1;
            r_rx_code <= 2'b11;
          end else if (!r_hdr[6]) begin
            r_rx_err  <= 1'b1;
            r_rx_code <= 2'b01;
          end else if (w_len_bad) begin
            r_rx_err  <= 1'b1;
            r_rx_code <= 2'b10;
          end else if (!r_rx_valid || rx_ready) begin
            // a same-edge consume frees the slot, so the new record loads
            r_rx_len   <= r_hdr[5:0];
            r_rx_pfx   <= r_sh;
            r_rx_valid <= 1'b1;
          end else begin
            r_rx_drop <= 1'b1;
          end
        end
        default: r_rx_st <= R_ARM;
      endcase
    end
  end

  assign w_acc  = tx_data_valid & r_trdy;
  assign w_bidx = TCW'(BW - 2) - r_tcnt;

  // tx_line is registered one cycle ahead: each edge sets the next bit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tx_st <= T_LOAD;
      r_tcnt  <= '0;
      r_ifg   <= '0;
      r_woff  <= TCW'(BW - 8);
      r_buf   <= '0;
      r_line  <= 1'b1;
      r_trdy  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      unique case (r_tx_st)
        T_LOAD: begin
          r_trdy <= 1'b1;
          if (w_acc) begin
            r_buf[r_woff +: 8] <= tx_data;
            r_busy             <= 1'b1;
            if (r_woff == '0) begin
              r_trdy  <= 1'b0;
              r_line  <= 1'b0;
              r_woff  <= TCW'(BW - 8);
              r_tx_st <= T_START;
            end else begin
              r_woff <= r_woff - TCW'(8);
            end
          end
        end
        T_START: begin
          r_tcnt  <= '0;
          r_tx_st <= T_HDR;
        end
        T_HDR: begin
          if (r_tcnt == TCW'(7)) begin
            r_line  <= r_buf[BW-1];
            r_tcnt  <= '0;
            r_tx_st <= T_BODY;
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end
        T_BODY: begin
          if (r_tcnt == TCW'(BW - 1)) begin
            r_line  <= 1'b0;
            r_tx_st <= T_END;
          end else begin
            r_line <= r_buf[w_bidx];
            r_tcnt <= r_tcnt + 1'b1;
          end
        end
        T_END: begin
          r_line  <= 1'b1;
          r_ifg   <= '0;
          r_tx_st <= T_IFG;
        end
        T_IFG: begin
          if (r_ifg == IFW'(IFG_BITS - 1)) begin
            r_busy  <= 1'b0;
            r_trdy  <= 1'b1;
            r_tx_st <= T_LOAD;
          end else begin
            r_ifg <= r_ifg + 1'b1;
          end
        end
        default: r_tx_st <= T_LOAD;
      endcase
    end
  end

  assign rx_valid      = r_rx_valid;
  assign rx_length     = r_rx_len;
  assign rx_prefix     = r_rx_pfx;
  assign rx_err        = r_rx_err;
  assign rx_err_code   = r_rx_code;
  assign rx_drop       = r_rx_drop;
  assign tx_line       = r_line;
  assign tx_data_ready = r_trdy;
  assign tx_busy       = r_busy;

endmodule

// File: tb/tb_spi_mcu_framer.sv
// tb_spi_mcu_framer: scoreboard bench for the MCU serial framer.
// RX records/errors and TX line bits are queued as driven and popped as observed.
module tb_spi_mcu_framer #(
  parameter int PW  = 64,
  parameter int PB  = 4,
  parameter int IFG = 2
);

  logic          clk = 1'b0;
  logic          rst;
  logic          rx_line;
  logic          tx_line;
  logic          rx_valid;
  logic          rx_ready;
  logic [5:0]    rx_length;
  logic [PW-1:0] rx_prefix;
  logic          rx_err;
  logic [1:0]    rx_err_code;
  logic          rx_drop;
  logic [7:0]    tx_data;
  logic          tx_data_valid;
  logic          tx_data_ready;
  logic          tx_busy;

  typedef struct packed {
    logic [5:0]    len;
    logic [PW-1:0] pfx;
  } rec_t;

  rec_t       exp_rec[$];
  rec_t       got_rec[$];
  logic [1:0] exp_err[$];
  logic [1:0] got_err[$];
  logic       txq[$];
  int n_cmp  = 0;
  int n_fail = 0;
  int n_drop = 0;
  int n_vhi  = 0;

  spi_mcu_framer #(
    .PREFIX_W(PW), .PAYLOAD_BYTES(PB), .IFG_BITS(IFG)
  ) dut (
    .clk(clk), .rst(rst), .rx_line(rx_line), .tx_line(tx_line),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_length(rx_length),
    .rx_prefix(rx_prefix), .rx_err(rx_err), .rx_err_code(rx_err_code),
    .rx_drop(rx_drop), .tx_data(tx_data), .tx_data_valid(tx_data_valid),
    .tx_data_ready(tx_data_ready), .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  // sees exactly what the DUT will see at the coming posedge
  always @(negedge clk) begin
    #1;
    if (rst) begin
      if (rx_valid && rx_ready) got_rec.push_back(rec_t'({rx_length, rx_prefix}));
      if (rx_err) got_err.push_back(rx_err_code);
      if (rx_drop) n_drop++;
      if (rx_valid) n_vhi++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] byte_of(input int i);
    case (i % 4)
      0: return 8'hA5;
      1: return 8'h3C;
      2: return 8'h01;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic rec_t mk(input logic [5:0] l, input logic [63:0] p);
    rec_t r;
    r.len = l;
    r.pfx = PW'(p);
    return r;
  endfunction

  task automatic rx_send(input logic [7:0] hdr, input logic [PW-1:0] pfx, input logic endb);
    @(negedge clk) rx_line = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      @(negedge clk) rx_line = hdr[i];
    end
    for (int i = PW - 1; i >= 0; i--) begin
      @(negedge clk) rx_line = pfx[i];
    end
    @(negedge clk) rx_line = endb;
  endtask

  task automatic rx_idle(input int n);
    repeat (n) @(negedge clk) rx_line = 1'b1;
  endtask

  task automatic push_frame(input int xr);
    txq.push_back(1'b0);
    repeat (8) txq.push_back(1'b0);
    for (int i = 0; i < PB; i++) begin
      logic [7:0] b;
      b = byte_of(i) ^ 8'(xr);
      for (int k = 7; k >= 0; k--) txq.push_back(b[k]);
    end
    txq.push_back(1'b0);
  endtask

  task automatic tx_offer(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    tx_data = b;
    tx_data_valid = 1'b1;
    while (tx_data_ready !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      n_cmp++;
      n_fail++;
      $display("FAIL tx_offer timeout ready=%b", tx_data_ready);
    end
    @(negedge clk) tx_data_valid = 1'b0;
  endtask

  task automatic tx_capture(input string nm);
    int n, busy_bad, rdy_bad;
    logic e;
    n = 0;
    busy_bad = 0;
    rdy_bad = 0;
    @(negedge clk);
    while (tx_line !== 1'b0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (n >= 3000) begin
      n_fail++;
      $display("FAIL %s_start got no start bit, tx_line=%b", nm, tx_line);
      return;
    end
    for (int i = 0; i < 10 + 8 * PB; i++) begin
      e = txq.pop_front();
      n_cmp++;
      if (tx_line !== e) begin
        n_fail++;
        $display("FAIL %s_bit%0d got %b want %b", nm, i, tx_line, e);
      end
      if (tx_busy !== 1'b1) busy_bad++;
      if (tx_data_ready !== 1'b0) rdy_bad++;
      @(negedge clk);
    end
    for (int i = 0; i < IFG; i++) begin
      n_cmp++;
      if (tx_line !== 1'b1) begin
        n_fail++;
        $display("FAIL %s_ifg%0d got %b want 1", nm, i, tx_line);
      end
      if (tx_busy !== 1'b1) busy_bad++;
      @(negedge clk);
    end
    n_cmp++;
    if (tx_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_busy_end got %b want 0", nm, tx_busy);
    end
    n_cmp++;
    if (busy_bad != 0) begin
      n_fail++;
      $display("FAIL %s_busy_low got %0d low cycles want 0", nm, busy_bad);
    end
    n_cmp++;
    if (rdy_bad != 0) begin
      n_fail++;
      $display("FAIL %s_ready_high got %0d cycles want 0", nm, rdy_bad);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp += 8;
    if (tx_line !== 1'b1) begin n_fail++; $display("FAIL rst_tx_line got %b want 1", tx_line); end
    if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rx_valid got %b want 0", rx_valid); end
    if (rx_err !== 1'b0) begin n_fail++; $display("FAIL rst_rx_err got %b want 0", rx_err); end
    if (rx_drop !== 1'b0) begin n_fail++; $display("FAIL rst_rx_drop got %b want 0", rx_drop); end
    if (tx_data_ready !== 1'b0) begin n_fail++; $display("FAIL rst_tx_ready got %b want 0", tx_data_ready); end
    if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL rst_tx_busy got %b want 0", tx_busy); end
    if (rx_length !== 6'd0) begin n_fail++; $display("FAIL rst_rx_length got %0d want 0", rx_length); end
    if (rx_prefix !== '0) begin n_fail++; $display("FAIL rst_rx_prefix got %h want 0", rx_prefix); end
    rst = 1'b1;
    rx_idle(3);
    n_cmp++;
    if (tx_data_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready got %b want 1", tx_data_ready); end
  endtask

  task automatic test_good();
    rec_t a, b, g;
    int e0;
    rx_ready = 1'b1;
    e0 = got_err.size();
    a = mk(6'(PW / 8), 64'hDEADBEEF_CAFEF00D);
    exp_rec.push_back(a);
    rx_send({2'b01, a.len}, a.pfx, 1'b0);
    @(negedge clk) rx_line = 1'b1;
    n_cmp++;
    if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL good_early got valid=%b want 0", rx_valid); end
    @(negedge clk);
    n_cmp += 3;
    if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL good_latency got valid=%b want 1", rx_valid); end
    if (rx_length !== a.len) begin n_fail++; $display("FAIL good_len got %0d want %0d", rx_length, a.len); end
    if (rx_prefix !== a.pfx) begin n_fail++; $display("FAIL good_pfx got %h want %h", rx_prefix, a.pfx); end
    @(negedge clk);
    n_cmp++;
    if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL good_one_cycle got valid=%b want 0", rx_valid); end
    rx_idle(3);
    b = mk(6'd1, 64'h01234567_89ABCDEF);
    exp_rec.push_back(b);
    rx_send({2'b11, b.len}, b.pfx, 1'b0);
    rx_idle(5);
    while (exp_rec.size() > 0) begin
      a = exp_rec.pop_front();
      n_cmp++;
      if (got_rec.size() == 0) begin
        n_fail++;
        $display("FAIL good_rec got none want %0d/%h", a.len, a.pfx);
      end else begin
        g = got_rec.pop_front();
        if (g !== a) begin n_fail++; $display("FAIL good_rec got %0d/%h want %0d/%h", g.len, g.pfx, a.len, a.pfx); end
      end
    end
    n_cmp += 2;
    if (got_rec.size() != 0) begin n_fail++; $display("FAIL good_extra got %0d records want 0", got_rec.size()); end
    if (got_err.size() != e0) begin n_fail++; $display("FAIL good_noerr got %0d errs want %0d", got_err.size(), e0); end
    got_rec.delete();
  endtask

  task automatic test_errors();
    logic [7:0] hd[6];
    logic       eb[6];
    logic [1:0] cd[6];
    logic [1:0] e, g;
    int v0;
    logic [5:0] ok_len, big_len;
    ok_len  = 6'(PW / 8);
    big_len = 6'(PW / 8 + 1);
    hd = '{{2'b00, ok_len}, {2'b01, big_len}, {2'b01, ok_len},
           {2'b01, 6'd0}, {2'b00, ok_len}, {2'b10, 6'd0}};
    eb = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    cd = '{2'b01, 2'b10, 2'b11, 2'b10, 2'b11, 2'b01};
    rx_ready = 1'b1;
    got_err.delete();
    v0 = n_vhi;
    for (int i = 0; i < 6; i++) begin
      exp_err.push_back(cd[i]);
      rx_send(hd[i], PW'(64'h0F1E2D3C_4B5A6978), eb[i]);
      rx_idle(4);
    end
    while (exp_err.size() > 0) begin
      e = exp_err.pop_front();
      n_cmp++;
      if (got_err.size() == 0) begin
        n_fail++;
        $display("FAIL err_code got none want %b", e);
      end else begin
        g = got_err.pop_front();
        if (g !== e) begin n_fail++; $display("FAIL err_code got %b want %b", g, e); end
      end
    end
    n_cmp += 2;
    if (n_vhi != v0) begin n_fail++; $display("FAIL err_valid got %0d valid cycles want 0", n_vhi - v0); end
    if (got_err.size() != 0) begin n_fail++; $display("FAIL err_extra got %0d want 0", got_err.size()); end
    got_err.delete();
  endtask

  task automatic test_hold_drop();
    rec_t a, b, c, x, g;
    int d0;
    a = mk(6'(PW / 8), 64'h11112222_33334444);
    b = mk(6'd1, 64'h55556666_77778888);
    c = mk(6'(PW / 8), 64'h0F0F0F0F_F0F0F0F0);
    d0 = n_drop;
    @(negedge clk) rx_ready = 1'b0;
    exp_rec.push_back(a);
    rx_send({2'b01, a.len}, a.pfx, 1'b0);
    rx_idle(3);
    rx_send({2'b01, b.len}, b.pfx, 1'b0);
    rx_idle(3);
    n_cmp += 4;
    if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL hold_valid got %b want 1", rx_valid); end
    if (rx_length !== a.len) begin n_fail++; $display("FAIL hold_len got %0d want %0d", rx_length, a.len); end
    if (rx_prefix !== a.pfx) begin n_fail++; $display("FAIL hold_pfx got %h want %h", rx_prefix, a.pfx); end
    if (n_drop - d0 != 1) begin n_fail++; $display("FAIL hold_drop got %0d pulses want 1", n_drop - d0); end
    exp_rec.push_back(c);
    rx_send({2'b01, c.len}, c.pfx, 1'b0);
    @(negedge clk);
    rx_line = 1'b1;
    rx_ready = 1'b1;
    @(negedge clk);
    n_cmp += 2;
    if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL same_edge_valid got %b want 1", rx_valid); end
    if (rx_prefix !== c.pfx) begin n_fail++; $display("FAIL same_edge_pfx got %h want %h", rx_prefix, c.pfx); end
    rx_idle(3);
    while (exp_rec.size() > 0) begin
      x = exp_rec.pop_front();
      n_cmp++;
      if (got_rec.size() == 0) begin
        n_fail++;
        $display("FAIL hold_rec got none want %0d/%h", x.len, x.pfx);
      end else begin
        g = got_rec.pop_front();
        if (g !== x) begin n_fail++; $display("FAIL hold_rec got %0d/%h want %0d/%h", g.len, g.pfx, x.len, x.pfx); end
      end
    end
    n_cmp += 2;
    if (got_rec.size() != 0) begin n_fail++; $display("FAIL hold_extra got %0d want 0", got_rec.size()); end
    if (n_drop - d0 != 1) begin n_fail++; $display("FAIL same_edge_drop got %0d pulses want 1", n_drop - d0); end
    got_rec.delete();
  endtask

  task automatic test_tx();
    txq.delete();
    push_frame(0);
    fork
      for (int i = 0; i < PB; i++) tx_offer(byte_of(i));
      tx_capture("tx");
    join
    n_cmp++;
    if (txq.size() != 0) begin n_fail++; $display("FAIL tx_left got %0d bits want 0", txq.size()); end
  endtask

  task automatic test_back_to_back();
    txq.delete();
    push_frame(0);
    push_frame(8'h5A);
    fork
      for (int i = 0; i < 2 * PB; i++)
        tx_offer((i < PB) ? byte_of(i) : (byte_of(i - PB) ^ 8'h5A));
      begin
        tx_capture("b2b_a");
        tx_capture("b2b_b");
      end
    join
    n_cmp++;
    if (txq.size() != 0) begin n_fail++; $display("FAIL b2b_left got %0d bits want 0", txq.size()); end
  endtask

  task automatic test_reset_mid();
    logic [3:0] bits;
    int e0, v0;
    bits = 4'b0010;
    rx_ready = 1'b1;
    for (int i = 0; i < PB; i++) tx_offer(byte_of(i));
    for (int i = 3; i >= 0; i--) begin
      @(negedge clk) rx_line = bits[i];
    end
    n_cmp += 2;
    if (tx_line !== 1'b0) begin n_fail++; $display("FAIL mid_pre_line got %b want 0", tx_line); end
    if (tx_busy !== 1'b1) begin n_fail++; $display("FAIL mid_pre_busy got %b want 1", tx_busy); end
    #2;
    rst = 1'b0;
    rx_line = 1'b0;
    #1;
    n_cmp += 4;
    if (tx_line !== 1'b1) begin n_fail++; $display("FAIL mid_rst_line got %b want 1", tx_line); end
    if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy got %b want 0", tx_busy); end
    if (tx_data_ready !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ready got %b want 0", tx_data_ready); end
    if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid got %b want 0", rx_valid); end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    e0 = got_err.size();
    v0 = n_vhi;
    repeat (12) @(negedge clk);
    rx_idle(4);
    n_cmp += 3;
    if (got_err.size() != e0) begin n_fail++; $display("FAIL mid_spur_err got %0d want 0", got_err.size() - e0); end
    if (n_vhi != v0) begin n_fail++; $display("FAIL mid_spur_valid got %0d want 0", n_vhi - v0); end
    if (tx_line !== 1'b1) begin n_fail++; $display("FAIL mid_idle_line got %b want 1", tx_line); end
    got_rec.delete();
    test_good();
    test_tx();
  endtask

  initial begin
    rst = 1'b0;
    rx_line = 1'b1;
    rx_ready = 1'b1;
    tx_data = 8'h00;
    tx_data_valid = 1'b0;
    test_reset();
    test_good();
    test_errors();
    test_hold_drop();
    test_tx();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
